// File: rtl/ram_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-port RAM with synchronous read.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; by default a tie goes to port 1.
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q;
  logic              winner_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic              wrEn_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic [DATA_W-1:0] ramWdata_q;

  logic              tieWinner;
  logic              winner_d;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic lastGnt_q;
  assign tieWinner = ~lastGnt_q;
`else
  assign tieWinner = 1'b1;
`endif

  always_comb begin
    winner_d = p1_req;
    if (p0_req && p1_req) winner_d = tieWinner;
  end

  assign selWe    = winner_d ? p1_we    : p0_we;
  assign selAddr  = winner_d ? p1_addr  : p0_addr;
  assign selWdata = winner_d ? p1_wdata : p0_wdata;

  // ram_addr/ram_wdata double as the latched command, so they hold between accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      winner_q   <= 1'b0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      wrEn_q     <= 1'b0;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      lastGnt_q  <= 1'b1;
`endif
    end else begin
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      wrEn_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            state_q    <= ACCESS;
            winner_q   <= winner_d;
            gnt_q      <= winner_d ? 2'b10 : 2'b01;
            wrEn_q     <= selWe;
            ramAddr_q  <= selAddr;
            ramWdata_q <= selWdata;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            lastGnt_q  <= winner_d;
`endif
          end
        end
        ACCESS: begin
          if (wrEn_q) begin
            state_q <= IDLE;
          end else begin
            state_q  <= RESP;
            rvalid_q <= winner_q ? 2'b10 : 2'b01;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps a reset asserted mid-ACCESS from committing the write.
  assign ram_wr_en = wrEn_q & rst;
  assign ram_addr  = ramAddr_q;
  assign ram_wdata = ramWdata_q;

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = rvalid_q[0] ? ram_rdata : '0;
  assign p1_rdata  = rvalid_q[1] ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honours RAM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam int TIE_FIRST = 0;
`else
  localparam int TIE_FIRST = 1;
`endif

  logic              clk;
  logic              rst;
  logic              p0_req, p1_req, p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: each granted transaction is scheduled as events on absolute cycle numbers.
  logic [DATA_W-1:0] refMem [DEPTH];
  int                edgeNo  = 0;
  bit                modelOn = 1'b0;
  int                freeAt  = 0;
  int                gntCyc  = -1, gntPort = 0;
  int                rvCyc   = -1, rvPort  = 0;
  int                wrCyc   = -1;
  int                winner;
  bit                lastGnt = 1'b1;
  logic [DATA_W-1:0] rvData;
  logic [ADDR_W-1:0] expAddr, wrAddr;
  logic [DATA_W-1:0] expWdata, wrData;

  always @(posedge clk) begin
    edgeNo = edgeNo + 1;
    if (!rst) begin
      modelOn  = 1'b1;
      freeAt   = edgeNo + 1;
      gntCyc   = -1;
      rvCyc    = -1;
      wrCyc    = -1;
      expAddr  = '0;
      expWdata = '0;
      lastGnt  = 1'b1;
    end else if (modelOn) begin
      if (wrCyc == edgeNo - 1) refMem[wrAddr] = wrData;
      if (edgeNo >= freeAt && (p0_req || p1_req)) begin
        if (p0_req && p1_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          winner = lastGnt ? 0 : 1;
`else
          winner = 1;
`endif
        end else begin
          winner = p1_req ? 1 : 0;
        end
        lastGnt  = (winner == 1);
        gntCyc   = edgeNo;
        gntPort  = winner;
        expAddr  = (winner == 1) ? p1_addr : p0_addr;
        expWdata = (winner == 1) ? p1_wdata : p0_wdata;
        if ((winner == 1) ? p1_we : p0_we) begin
          wrCyc  = edgeNo;
          wrAddr = expAddr;
          wrData = expWdata;
          freeAt = edgeNo + 2;
        end else begin
          wrCyc  = -1;
          rvCyc  = edgeNo + 1;
          rvPort = winner;
          rvData = refMem[expAddr];
          freeAt = edgeNo + 3;
        end
      end
    end
  end

  logic [1:0]        expGnt, expRv;
  logic [DATA_W-1:0] expRd0, expRd1;
  logic              expWe;

  always @(negedge clk) begin
    if (modelOn) begin
      expGnt = 2'b00;
      expRv  = 2'b00;
      expRd0 = '0;
      expRd1 = '0;
      if (gntCyc == edgeNo) expGnt[gntPort] = 1'b1;
      if (rvCyc == edgeNo) begin
        expRv[rvPort] = 1'b1;
        if (rvPort == 0) expRd0 = rvData;
        else             expRd1 = rvData;
      end
      expWe = (wrCyc == edgeNo) && rst;
      checkOutput("gnt", {p1_gnt, p0_gnt}, expGnt);
      checkOutput("rvalid", {p1_rvalid, p0_rvalid}, expRv);
      checkOutput("p0_rdata", p0_rdata, expRd0);
      checkOutput("p1_rdata", p1_rdata, expRd1);
      checkOutput("ram_wr_en", ram_wr_en, expWe);
      checkOutput("ram_addr", ram_addr, expAddr);
      checkOutput("ram_wdata", ram_wdata, expWdata);
    end
  end

  task automatic issue(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    bit got = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data;
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? p0_gnt : p1_gnt;
    end
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
    checkOutput("gntSeen", got, 1);
  endtask

  task automatic readCheck(input int port, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] expData, input string tag);
    issue(port, 1'b0, addr, '0);
    @(negedge clk);
    checkOutput({tag, "_rvalid"}, (port == 0) ? p0_rvalid : p1_rvalid, 1);
    checkOutput({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, expData);
  endtask

  task automatic applyReset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W-1:0] pickAddr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return ADDR_W'($urandom_range(0, 7));
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      rst      = ($urandom_range(0, 59) != 0);
      p0_req   = ($urandom_range(0, 2) != 0);
      p0_we    = ($urandom_range(0, 1) == 1);
      p0_addr  = pickAddr();
      p0_wdata = $urandom;
      p1_req   = ($urandom_range(0, 2) != 0);
      p1_we    = ($urandom_range(0, 1) == 1);
      p1_addr  = pickAddr();
      p1_wdata = $urandom;
    end
    @(negedge clk);
    #1;
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
  endtask

  int firstPort, lastCyc, lastPort, thisPort, n0, n1, badGap, samePort;
  bit done0, done1;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ramMem[i] = '0;
      refMem[i] = '0;
    end
    rst = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    issue(0, 1'b1, 10'd5, 32'd260);
    readCheck(0, 10'd5, 32'd260, "rdAddr5");

    issue(1, 1'b1, 10'd1023, 32'hFFFF_FFFF);
    issue(0, 1'b1, 10'd0, 32'h1);
    readCheck(1, 10'd1023, 32'hFFFF_FFFF, "rdTop");
    readCheck(0, 10'd0, 32'h1, "rdZero");

    // Reset lands in the ACCESS cycle of the 0xDEAD write.
    issue(0, 1'b1, 10'd7, 32'h1234);
    issue(0, 1'b1, 10'd7, 32'hDEAD);
    #1 rst = 1'b0;
    #1 checkOutput("rstWrEn", ram_wr_en, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstCtrl", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_wr_en}, 0);
    checkOutput("rstRam", {ram_addr, ram_wdata}, 0);
    checkOutput("rstRdata", {p0_rdata, p1_rdata}, 0);
    readCheck(0, 10'd7, 32'h1234, "rdAddr7");

    applyReset();
    p0_we = 1'b1; p0_addr = 10'd1; p0_wdata = 32'hA;
    p1_we = 1'b1; p1_addr = 10'd2; p1_wdata = 32'hB;
    p0_req = 1'b1; p1_req = 1'b1;
    firstPort = -1; done0 = 1'b0; done1 = 1'b0;
    for (int i = 0; i < 12 && !(done0 && done1); i++) begin
      @(negedge clk);
      if (p0_gnt) begin
        if (firstPort < 0) firstPort = 0;
        done0 = 1'b1; p0_req = 1'b0;
      end
      if (p1_gnt) begin
        if (firstPort < 0) firstPort = 1;
        done1 = 1'b1; p1_req = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checkOutput("tieFirst", firstPort, TIE_FIRST);
    checkOutput("tieBoth", {done0, done1}, 2'b11);
    readCheck(0, 10'd1, 32'hA, "rdTie0");
    readCheck(1, 10'd2, 32'hB, "rdTie1");

    repeat (3) @(negedge clk);
    p0_we = 1'b0; p0_addr = 10'd5;
    p1_we = 1'b0; p1_addr = 10'd1023;
    p0_req = 1'b1; p1_req = 1'b1;
    lastCyc = -1; lastPort = -1; n0 = 0; n1 = 0; badGap = 0; samePort = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) begin
        thisPort = p1_gnt ? 1 : 0;
        if (lastCyc >= 0) begin
          if (c - lastCyc != 3) badGap++;
          if (thisPort == lastPort) samePort++;
        end
        lastCyc = c;
        lastPort = thisPort;
        if (thisPort == 1) n1++;
        else               n0++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checkOutput("contGap", badGap, 0);
    checkOutput("contGrants", n0 + n1, 10);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    checkOutput("contAlternate", samePort, 0);
    checkOutput("contP0Count", n0, 5);
`else
    checkOutput("contP0Count", n0, 0);
`endif

    repeat (3) @(negedge clk);
    applyStimulus(800);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001: Parameter ADDR_W, default 10, RAM word-address width.
REQ-002: Parameter DATA_W, default 32, RAM data width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-low.
REQ-005: p0_req / p1_req  input  1 each  request from port 0 (fetch) / port 1 (load-store).
REQ-006: p0_we / p1_we  input  1 each  1 = write, 0 = read.
REQ-007: p0_addr / p1_addr  input  ADDR_W each  word address.
REQ-008: p0_wdata / p1_wdata  input  DATA_W each  write data.
REQ-009: p0_gnt / p1_gnt  output  1 each  one-cycle grant pulse.
REQ-010: p0_rvalid / p1_rvalid  output  1 each  one-cycle read-data-valid pulse.
REQ-011: p0_rdata / p1_rdata  output  DATA_W each  read data.
REQ-012: ram_wr_en  output  1  RAM write enable.
REQ-013: ram_addr  output  ADDR_W  RAM address.
REQ-014: ram_wdata  output  DATA_W  RAM write data.
REQ-015: ram_rdata  input  DATA_W  RAM read data, valid one clk after ram_addr is presented (synchronous read).

Function
REQ-016: The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017: In IDLE, when any pN_req is 1 at an edge, the FSM SHALL latch the winner's we/addr/wdata, record the winner, and enter ACCESS.
REQ-018: pN_req SHALL be sampled only in IDLE; a request dropped before sampling is not served.
REQ-019: In ACCESS, the FSM SHALL assert the winner's pN_gnt for exactly that cycle and drive ram_addr/ram_wdata from the latched command.
REQ-020: In ACCESS, ram_wr_en SHALL equal the latched we; ram_wr_en SHALL be 0 in every other state.
REQ-021: A write SHALL go ACCESS -> IDLE; a read SHALL go ACCESS -> RESP -> IDLE.
REQ-022: In RESP, the winner's pN_rvalid SHALL be 1 and pN_rdata SHALL equal ram_rdata.
REQ-023: When pN_rvalid is 0, pN_rdata SHALL be 0.
REQ-024: Timing from the request-sampling edge E: gnt in the cycle after E; rvalid in the cycle after that.
REQ-025: Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-026: ram_addr and ram_wdata SHALL hold their last values outside ACCESS.
REQ-027: Only one pN_gnt and at most one pN_rvalid SHALL be high in any cycle.
REQ-028: A sole requester SHALL always win; a tie SHALL be resolved per REQ-034.
REQ-029: Addresses 0 through 2^ADDR_W-1 SHALL pass through unmodified, with no wrap or offset.

Reset
REQ-030: While rst is 0 at an edge, the FSM SHALL enter IDLE and abandon any in-flight transaction.
REQ-031: After reset, all pN_gnt, pN_rvalid, pN_rdata, ram_wr_en, ram_addr and ram_wdata SHALL be 0.
REQ-032: ram_wr_en SHALL be forced to 0 combinationally whenever rst is 0, so no RAM write can occur during a reset cycle.
REQ-033: After reset, the last-grant register SHALL be 1, so port 0 wins the first tie.

Configuration
REQ-034: Macro RAM_ARB_ROUND_ROBIN_EN defined: a tie SHALL go to the port not recorded as the last granted; the last-grant register SHALL update on every grant; a continuously requesting port SHALL be granted within two arbitration rounds.
REQ-035: Macro RAM_ARB_ROUND_ROBIN_EN undefined: a tie SHALL always go to port 1 (fixed priority), and no last-grant register SHALL exist.

Verification
REQ-036: p0 write addr 5, data 260, then p0 read addr 5 -> p0_gnt pulses for each; p0_rvalid=1 with p0_rdata=260 two cycles after the read is sampled.
REQ-037: After reset, p0 and p1 both write in the same cycle (addr 1 = 0xA, addr 2 = 0xB) -> with RAM_ARB_ROUND_ROBIN_EN, p0 is granted first, then p1; readback returns 0xA and 0xB.
REQ-038: Both ports hold continuous reads -> with the macro, grants alternate 0,1,0,1 with a gap of 3 cycles; without the macro, only p1 is ever granted.
REQ-039: rst=0 during an ACCESS write of 0xDEAD to addr 7 -> ram_wr_en=0 in that cycle; addr 7 readback returns its old value; outputs are 0 the following cycle.
REQ-040: Write 0xFFFFFFFF to addr 1023 and 0x1 to addr 0, then read both back -> exact values returned, with no aliasing between addresses.
